dispense_cmd_parser: RTL and testbench
======================================

Name: dispense_cmd_parser

Overview:
Read-side consumer of the command byte FIFO (fifo_sync). It pops bytes, reassembles fixed 4-byte dispense command frames, validates them, and presents one command at a time to the dispenser controller over a valid/ready handshake. It also flags malformed, stale or out-of-range frames and keeps saturating good/error frame counters.

Parameters:
NUM_SLOTS, 8, number of physical medicine slots; a frame with slot >= NUM_SLOTS is rejected.
TIMEOUT_CYCLES, 50000, maximum idle cycles between processed bytes inside a frame; must be >= 2.
CNT_W, 16, width of the good/error frame counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request; combinational
fifo_dout  in  8  FIFO read data, valid the cycle after an accepted pop
cmd_valid  out  1  command available
cmd_ready  in  1  controller accepts the command
cmd_slot  out  8  slot index
cmd_count  out  8  number of doses, 1..255
err_pulse  out  1  one-cycle error strobe
err_code  out  2  01 = checksum, 10 = timeout, 11 = bad argument; held until the next error
frames_ok  out  CNT_W  saturating count of accepted frames
frames_err  out  CNT_W  saturating count of rejected frames

Behaviour:
- Frame format: SOF = 0xA5, SLOT, COUNT, CHK. Valid only if CHK == 0xA5 ^ SLOT ^ COUNT.
- States: HUNT, SLOT, COUNT, CHK, HOLD.
- FIFO read rules:
  - fifo_rd_en = !fifo_empty && state != HOLD && !(state == CHK && rd_pend).
  - rd_pend is a register loaded with fifo_rd_en each cycle.
  - A byte is "processed" only in a cycle with rd_pend = 1, using fifo_dout in that cycle. fifo_dout is ignored in all other cycles.
  - Back-to-back pops are allowed, giving 1 byte/cycle sustained.
- State transitions on a processed byte:
  - HUNT: byte == 0xA5 -> SLOT. Otherwise stay in HUNT, silently; not an error and not counted.
  - SLOT: latch the byte into slot_r -> COUNT.
  - COUNT: latch the byte into count_r -> CHK.
  - CHK, in priority order:
    - Checksum mismatch -> err 01 -> HUNT.
    - count_r == 0 or slot_r >= NUM_SLOTS -> err 11 -> HUNT.
    - Otherwise -> HOLD with cmd_valid = 1.
- Timeout:
  - An idle counter runs in SLOT/COUNT/CHK and clears on every processed byte and on entry to SLOT.
  - When it reaches TIMEOUT_CYCLES-1 with no byte processed: err 10 -> HUNT.
  - If rd_pend = 1 in that same cycle, the byte wins and there is no timeout.
- HOLD:
  - cmd_valid = 1; cmd_slot and cmd_count stay stable; no pops are issued.
  - On cmd_ready: frames_ok++ and go to HUNT; cmd_valid deasserts next cycle. Latency from CHK byte processed to cmd_valid is 1 cycle.
  - cmd_ready while cmd_valid = 0 is ignored.
- On any error: err_pulse = 1 for exactly the transition cycle+1 (registered); err_code updates in the same cycle; frames_err++.
- Counters: saturate at all-ones; no wrap.
- Reset values:
  - state = HUNT, rd_pend = 0, cmd_valid = 0.
  - cmd_slot = 0, cmd_count = 0.
  - err_pulse = 0, err_code = 00.
  - frames_ok = 0, frames_err = 0, idle counter = 0.
- Reset mid-frame: a partial frame and any in-flight pop are discarded. The popped byte is lost, and no error is reported.
- A FIFO that goes empty mid-frame is not an error until the timeout expires.

Decomposition:
- Package dispense_pkg:
  - SOF_BYTE = 8'hA5.
  - ERR_CHECKSUM / ERR_TIMEOUT / ERR_BADARG codes.
  - State enum encoding.
  - Frame length constant 4.
- One sub-module, sat_counter (parameter W; inputs inc/clr; saturating output), instantiated twice for frames_ok and frames_err.

Test Plan:
- Preload A5 03 02 A4, cmd_ready = 1 -> cmd_valid for 1 cycle with slot = 3, count = 2; frames_ok = 1; 4 pops on consecutive cycles.
- Preload 00 7F A5 01 01 A5 -> two junk bytes dropped silently, then cmd slot = 1, count = 1; frames_err = 0.
- A5 01 01 00 (bad CHK) -> err_pulse once, err_code = 01, frames_err = 1, no cmd_valid; a following good frame is still accepted.
- A5 02 00 A7 and A5 09 01 AD (NUM_SLOTS = 8) -> two err 11 pulses, frames_err = 2.
- A5 04, then FIFO held empty for TIMEOUT_CYCLES = 10 -> err 10 exactly 10 idle cycles after the last processed byte; the next A5 restarts the frame.
- Good frame with cmd_ready = 0 for 20 cycles while two more frames sit in the FIFO -> fifo_rd_en stays 0 and fields stay stable. Then assert rst mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dispense_pkg.sv
// Shared constants and types for the dispense command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dispense_pkg;

  // Start-of-frame marker; also seeds the XOR checksum.
  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  // SOF, SLOT, COUNT, CHK.
  localparam int         FRAME_LEN = 4;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_BADARG   = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_SLOT  = 3'd1,
    ST_COUNT = 3'd2,
    ST_CHK   = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/dispense_cmd_parser_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Latency: count reflects inc_i one cycle later.
// Backpressure: none; clr_i has priority over inc_i.
// Ports: clk, clr_i (sync clear), inc_i (increment request), cnt_o (count).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dispense_cmd_parser.sv
// Pops the command byte FIFO, reassembles 4-byte dispense frames, validates them.
// Latency: cmd_valid rises 1 cycle after the CHK byte is processed; 1 byte/cycle sustained.
// Backpressure: while a command waits for cmd_ready no further bytes are popped.
// Ports: clk/rst (sync, active-high); fifo_empty/fifo_rd_en/fifo_dout FIFO read side;
//        cmd_valid/cmd_ready/cmd_slot/cmd_count command handshake;
//        err_pulse/err_code error report; frames_ok/frames_err saturating counters.
module dispense_cmd_parser
  import dispense_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 50000,  // must be >= 2
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_dout,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_slot,
  output logic [7:0]       cmd_count,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              rd_pend_q;
  logic [7:0]        slot_q, slot_d;
  logic [7:0]        count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              err_evt, ok_evt;
  logic [1:0]        err_sel;
  logic              slot_bad;

  // No pop while holding a command, and no pop in CHK while the CHK byte is
  // already in flight: that keeps the next frame's SOF in the FIFO.
  assign fifo_rd_en = !fifo_empty && (state_q != ST_HOLD) &&
                      !((state_q == ST_CHK) && rd_pend_q);

  assign slot_bad = int'({24'd0, slot_q}) >= NUM_SLOTS;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    count_d     = count_q;
    idle_d      = idle_q;
    cmd_valid_d = cmd_valid_q;
    err_code_d  = err_code_q;
    err_evt     = 1'b0;
    err_sel     = ERR_NONE;
    ok_evt      = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        idle_d = '0;
        if (rd_pend_q && (fifo_dout == SOF_BYTE)) begin
          state_d = ST_SLOT;
        end
      end
      ST_SLOT, ST_COUNT, ST_CHK: begin
        // A byte landing in the timeout cycle wins over the timeout.
        if (rd_pend_q) begin
          idle_d = '0;
          if (state_q == ST_SLOT) begin
            slot_d  = fifo_dout;
            state_d = ST_COUNT;
          end else if (state_q == ST_COUNT) begin
            count_d = fifo_dout;
            state_d = ST_CHK;
          end else if (fifo_dout != (SOF_BYTE ^ slot_q ^ count_q)) begin
            err_evt = 1'b1;
            err_sel = ERR_CHECKSUM;
          end else if ((count_q == 8'd0) || slot_bad) begin
            err_evt = 1'b1;
            err_sel = ERR_BADARG;
          end else begin
            state_d     = ST_HOLD;
            cmd_valid_d = 1'b1;
          end
        end else if (idle_q == IDLE_MAX) begin
          err_evt = 1'b1;
          err_sel = ERR_TIMEOUT;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_HOLD: begin
        if (cmd_ready) begin
          ok_evt      = 1'b1;
          cmd_valid_d = 1'b0;
          state_d     = ST_HUNT;
        end
      end
      default: begin
        state_d     = ST_HUNT;
        cmd_valid_d = 1'b0;
      end
    endcase

    if (err_evt) begin
      err_code_d = err_sel;
      state_d    = ST_HUNT;
      idle_d     = '0;
    end
    err_pulse_d = err_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      rd_pend_q   <= 1'b0;
      slot_q      <= 8'd0;
      count_q     <= 8'd0;
      idle_q      <= '0;
      cmd_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= fifo_rd_en;
      slot_q      <= slot_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      cmd_valid_q <= cmd_valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (ok_evt),
    .cnt_o (frames_ok)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (err_evt),
    .cnt_o (frames_err)
  );

  assign cmd_valid = cmd_valid_q;
  assign cmd_slot  = slot_q;
  assign cmd_count = count_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_dispense_cmd_parser.sv
module tb_dispense_cmd_parser;
  import dispense_pkg::*;

  localparam int NSL  = 8;
  localparam int TO   = 10;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [7:0]    fifo_dout;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_slot;
  logic [7:0]    cmd_count;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [CW-1:0] frames_ok;
  logic [CW-1:0] frames_err;

  always #5 clk = ~clk;

  dispense_cmd_parser #(.NUM_SLOTS(NSL), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_slot   (cmd_slot),
    .cmd_count  (cmd_count),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

  typedef struct {
    int         len;
    logic [7:0] b [8];
    int         pops;
    int         n_cmd;
    logic [7:0] slot;
    logic [7:0] cnt;
    int         n_err;
    logic [1:0] code;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] fq [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         underflow = 0;
  logic       pop_now = 1'b0;
  int         first_pop, last_pop, first_vld;
  int         exp_ok = 0, exp_err = 0;
  logic [1:0] exp_code = 2'b00;

  function automatic vec_t mk(int len, logic [63:0] bytes, int n_cmd, logic [7:0] slot,
                              logic [7:0] cnt, int n_err, logic [1:0] code);
    vec_t v;
    v.len = len;
    for (int i = 0; i < 8; i++) v.b[i] = bytes[63-8*i -: 8];
    v.pops  = len;
    v.n_cmd = n_cmd;
    v.slot  = slot;
    v.cnt   = cnt;
    v.n_err = n_err;
    v.code  = code;
    return v;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample the pop request before the edge, then model a
  // registered-output FIFO by presenting the popped byte after the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    pop_now = pop;
    if (pop) begin
      if (fq.size() > 0) fifo_dout = fq.pop_front();
      else underflow++;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int ncmd, nerr, npop;
    logic [7:0] s, c;
    ncmd = 0; nerr = 0; npop = 0; s = 8'h00; c = 8'h00;
    for (int i = 0; i < v.len; i++) push(v.b[i]);
    cmd_ready = 1'b1;
    first_pop = -1; last_pop = -1; first_vld = -1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (pop_now) begin
        npop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (cmd_valid) begin
        ncmd++;
        s = cmd_slot;
        c = cmd_count;
        if (first_vld < 0) first_vld = cyc;
      end
      if (err_pulse) nerr++;
    end
    for (int i = 0; i < v.n_cmd; i++) exp_ok = sat_inc(exp_ok);
    for (int i = 0; i < v.n_err; i++) exp_err = sat_inc(exp_err);
    if (v.n_err > 0) exp_code = v.code;
    chk($sformatf("%s.pops", nm), npop, v.pops);
    chk($sformatf("%s.cmds", nm), ncmd, v.n_cmd);
    if (v.n_cmd > 0) begin
      chk($sformatf("%s.slot", nm), s, v.slot);
      chk($sformatf("%s.count", nm), c, v.cnt);
    end
    chk($sformatf("%s.err_pulses", nm), nerr, v.n_err);
    chk($sformatf("%s.err_code", nm), err_code, exp_code);
    chk($sformatf("%s.frames_ok", nm), frames_ok, exp_ok);
    chk($sformatf("%s.frames_err", nm), frames_err, exp_err);
  endtask

  task automatic chk_reset(input string nm);
    chk($sformatf("%s.cmd_valid", nm), cmd_valid, 0);
    chk($sformatf("%s.cmd_slot", nm), cmd_slot, 0);
    chk($sformatf("%s.cmd_count", nm), cmd_count, 0);
    chk($sformatf("%s.err_pulse", nm), err_pulse, 0);
    chk($sformatf("%s.err_code", nm), err_code, 0);
    chk($sformatf("%s.frames_ok", nm), frames_ok, 0);
    chk($sformatf("%s.frames_err", nm), frames_err, 0);
  endtask

  initial begin
    int err_cyc, nerr, bad_pop, bad_fld, got_vld;

    rst = 1'b1; cmd_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    tbl[0] = mk(FRAME_LEN, 64'hA5_03_02_A4_00_00_00_00, 1, 8'h03, 8'h02, 0, 2'b00);
    tbl[1] = mk(6,         64'h00_7F_A5_01_01_A5_00_00, 1, 8'h01, 8'h01, 0, 2'b00);
    tbl[2] = mk(FRAME_LEN, 64'hA5_01_01_00_00_00_00_00, 0, 8'h00, 8'h00, 1, ERR_CHECKSUM);
    tbl[3] = mk(FRAME_LEN, 64'hA5_03_02_A4_00_00_00_00, 1, 8'h03, 8'h02, 0, 2'b00);
    tbl[4] = mk(FRAME_LEN, 64'hA5_02_00_A7_00_00_00_00, 0, 8'h00, 8'h00, 1, ERR_BADARG);
    tbl[5] = mk(FRAME_LEN, 64'hA5_09_01_AD_00_00_00_00, 0, 8'h00, 8'h00, 1, ERR_BADARG);
    tbl[6] = mk(FRAME_LEN, 64'hA5_08_01_AC_00_00_00_00, 0, 8'h00, 8'h00, 1, ERR_BADARG);
    tbl[7] = mk(FRAME_LEN, 64'hA5_07_FF_5D_00_00_00_00, 1, 8'h07, 8'hFF, 0, 2'b00);
    tbl[8] = mk(8,         64'hA5_00_01_A4_A5_06_03_A0, 2, 8'h06, 8'h03, 0, 2'b00);
    tbl[9] = mk(8,         64'hA5_01_02_A6_A5_02_01_A6, 2, 8'h02, 8'h01, 0, 2'b00);

    step(); step();
    chk_reset("reset");
    chk("reset.rd_en_empty", fifo_rd_en, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("vec0.pop_span", last_pop - first_pop, FRAME_LEN - 1);
        chk("vec0.valid_latency", first_vld - first_pop, FRAME_LEN);
      end
    end

    // Timeout: SOF + SLOT, then the FIFO runs dry.
    push(8'hA5); push(8'h04);
    last_pop = -1; err_cyc = -1; nerr = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (pop_now) last_pop = cyc;
      if (err_pulse) begin
        nerr++;
        if (err_cyc < 0) err_cyc = cyc;
      end
    end
    exp_err = sat_inc(exp_err); exp_code = ERR_TIMEOUT;
    chk("timeout.pulses", nerr, 1);
    chk("timeout.delay", err_cyc - last_pop, TO + 1);
    chk("timeout.err_code", err_code, ERR_TIMEOUT);
    chk("timeout.frames_err", frames_err, exp_err);
    run_vec(mk(FRAME_LEN, 64'hA5_05_01_A1_00_00_00_00, 1, 8'h05, 8'h01, 0, 2'b00), "restart");

    // Short starvation inside a frame is not an error.
    push(8'hA5); push(8'h06);
    nerr = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (err_pulse) nerr++;
    end
    chk("gap.no_err", nerr, 0);
    run_vec(mk(2, 64'h02_A1_00_00_00_00_00_00, 1, 8'h06, 8'h02, 0, 2'b00), "gap");

    // Hold with backpressure while two more frames wait in the FIFO.
    cmd_ready = 1'b0;
    push(8'hA5); push(8'h02); push(8'h03); push(8'hA4);
    push(8'hA5); push(8'h01); push(8'h01); push(8'hA5);
    push(8'hA5); push(8'h04); push(8'h02); push(8'hA3);
    got_vld = 0;
    for (int k = 0; k < 20 && got_vld == 0; k++) begin
      step();
      if (cmd_valid) got_vld = 1;
    end
    chk("hold.valid_seen", got_vld, 1);
    bad_pop = 0; bad_fld = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pop_now) bad_pop++;
      if (!cmd_valid || cmd_slot != 8'h02 || cmd_count != 8'h03) bad_fld++;
    end
    chk("hold.no_pops", bad_pop, 0);
    chk("hold.fields_stable", bad_fld, 0);
    chk("hold.fifo_left", fq.size(), 8);
    cmd_ready = 1'b1;
    step();
    exp_ok = sat_inc(exp_ok);
    chk("hold.valid_drop", cmd_valid, 0);
    chk("hold.frames_ok", frames_ok, exp_ok);
    step(); step(); step();
    chk("midframe.slot", cmd_slot, 8'h01);
    chk("midframe.valid", cmd_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midrst");
    exp_ok = 0; exp_err = 0; exp_code = 2'b00;
    begin
      vec_t v;
      v = mk(0, 64'h0, 1, 8'h04, 8'h02, 0, 2'b00);
      v.pops = FRAME_LEN;
      run_vec(v, "postrst");
    end

    chk("fifo_underflow", underflow, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
